// File: rtl/usb_tx_pkg.sv
// Shared constants for the USB transmit data buffer: default depth, byte and
// size widths, and the pointer-width helper.
package usb_tx_pkg;

    localparam int USB_TX_BUF_DEPTH = 64;
    localparam int BYTE_W           = 8;
    localparam int SIZE_W           = 7;

    // One extra MSB beyond the index lets equal indices mean either full or empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/usb_tx_data_buffer_if.sv
// Bus between the protocol side, the transmitter and the TX data buffer.
// The replay/commit signals exist only when USB_TX_BUF_REPLAY_EN is defined.
interface usb_tx_data_buffer_if;
    import usb_tx_pkg::*;

    logic              store_tx_data;
    logic [BYTE_W-1:0] tx_data_in;
    logic              get_tx_packet_data;
    logic              flush;
    logic [BYTE_W-1:0] tx_packet_data;
    logic [SIZE_W-1:0] buffer_occupancy;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;
`ifdef USB_TX_BUF_REPLAY_EN
    logic              tx_replay;
    logic              tx_commit;

    modport master (
        output store_tx_data, tx_data_in, get_tx_packet_data, flush, tx_replay, tx_commit,
        input  tx_packet_data, buffer_occupancy, full, empty, overflow, underflow
    );
    modport slave (
        input  store_tx_data, tx_data_in, get_tx_packet_data, flush, tx_replay, tx_commit,
        output tx_packet_data, buffer_occupancy, full, empty, overflow, underflow
    );
`else
    modport master (
        output store_tx_data, tx_data_in, get_tx_packet_data, flush,
        input  tx_packet_data, buffer_occupancy, full, empty, overflow, underflow
    );
    modport slave (
        input  store_tx_data, tx_data_in, get_tx_packet_data, flush,
        output tx_packet_data, buffer_occupancy, full, empty, overflow, underflow
    );
`endif

endinterface

// File: rtl/tx_buffer_mem.sv
// DEPTH x 8 register file: one synchronous write port, one asynchronous read
// port, contents are never reset.
module tx_buffer_mem
    import usb_tx_pkg::*;
#(
    parameter int DEPTH = USB_TX_BUF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [BYTE_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [BYTE_W-1:0] o_rdata
);

    logic [BYTE_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/usb_tx_data_buffer.sv
// First-word-fall-through byte FIFO feeding the USB transmitter, with sticky
// overflow/underflow flags and synchronous flush. Optional USB_TX_BUF_REPLAY_EN
// retains read bytes until commit so a packet can be resent.
module usb_tx_data_buffer
    import usb_tx_pkg::*;
#(
    parameter int DEPTH = USB_TX_BUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  n_rst,
    usb_tx_data_buffer_if.slave   bus
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int AW    = PTR_W - 1;

    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic              r_overflow;
    logic              r_underflow;
    logic [PTR_W-1:0]  w_occ;
    logic [PTR_W-1:0]  w_held;
    logic              w_full;
    logic              w_empty;
    logic              w_wr;
    logic              w_rd;
    logic              w_rd_blocked;
    logic [BYTE_W-1:0] w_rdata;

`ifdef USB_TX_BUF_REPLAY_EN
    logic [PTR_W-1:0]  r_spt;

    // Bytes between spt and rptr are already sent but still owned by the buffer.
    assign w_held       = r_wptr - r_spt;
    assign w_rd         = bus.get_tx_packet_data & ~w_empty & ~bus.tx_replay;
    assign w_rd_blocked = bus.get_tx_packet_data & w_empty & ~bus.tx_replay;
`else
    assign w_held       = w_occ;
    assign w_rd         = bus.get_tx_packet_data & ~w_empty;
    assign w_rd_blocked = bus.get_tx_packet_data & w_empty;
`endif

    assign w_occ   = r_wptr - r_rptr;
    assign w_empty = (w_occ == '0);
    assign w_full  = (w_held == PTR_W'(DEPTH));
    assign w_wr    = bus.store_tx_data & ~w_full;

    tx_buffer_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (bus.tx_data_in),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    // Flush outranks every other operation; flags only ever set otherwise.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
`ifdef USB_TX_BUF_REPLAY_EN
            r_spt       <= '0;
`endif
        end else if (bus.flush) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
`ifdef USB_TX_BUF_REPLAY_EN
            r_spt       <= '0;
`endif
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
`ifdef USB_TX_BUF_REPLAY_EN
            if (bus.tx_replay) begin
                r_rptr <= r_spt;
            end else begin
                if (w_rd) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
                if (bus.tx_commit) begin
                    r_spt <= r_rptr;
                end
            end
`else
            if (w_rd) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
`endif
            if (bus.store_tx_data && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_rd_blocked) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.tx_packet_data   = w_empty ? '0 : w_rdata;
    assign bus.buffer_occupancy = SIZE_W'(w_occ);
    assign bus.full             = w_full;
    assign bus.empty            = w_empty;
    assign bus.overflow         = r_overflow;
    assign bus.underflow        = r_underflow;

endmodule

// File: tb/tb_usb_tx_data_buffer.sv
// Directed self-checking bench for usb_tx_data_buffer (DEPTH = 64); the replay
// section runs only when USB_TX_BUF_REPLAY_EN is defined.
module tb_usb_tx_data_buffer;

    logic clk;
    logic n_rst;
    int   testsRun;
    int   testsFailed;

    usb_tx_data_buffer_if bus ();

    usb_tx_data_buffer #(.DEPTH(64)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it and report any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of strobes, then release them 1ns after the edge.
    task automatic applyStimulus(input logic st, input logic [7:0] d, input logic gt, input logic fl);
        bus.store_tx_data      = st;
        bus.tx_data_in         = d;
        bus.get_tx_packet_data = gt;
        bus.flush              = fl;
        @(posedge clk);
        #1;
        bus.store_tx_data      = 1'b0;
        bus.get_tx_packet_data = 1'b0;
        bus.flush              = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_empty"}, 32'(bus.empty), 32'd1);
        checkOutput({tag, "_occ"},   32'(bus.buffer_occupancy), 32'd0);
        checkOutput({tag, "_data"},  32'(bus.tx_packet_data), 32'h00);
    endtask

    logic [7:0] model [$];
    logic [7:0] expByte;

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        n_rst       = 1'b0;
        bus.store_tx_data      = 1'b0;
        bus.tx_data_in         = 8'h00;
        bus.get_tx_packet_data = 1'b0;
        bus.flush              = 1'b0;
`ifdef USB_TX_BUF_REPLAY_EN
        bus.tx_replay = 1'b0;
        bus.tx_commit = 1'b0;
`endif
        #22 n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        checkIdle("reset");
        checkOutput("reset_full", 32'(bus.full), 32'd0);
        checkOutput("reset_ovf",  32'(bus.overflow), 32'd0);
        checkOutput("reset_udf",  32'(bus.underflow), 32'd0);

        // Two bytes in, two out
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        checkOutput("wr1_occ",  32'(bus.buffer_occupancy), 32'd1);
        checkOutput("wr1_data", 32'(bus.tx_packet_data), 32'hA5);
        checkOutput("wr1_empty", 32'(bus.empty), 32'd0);
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
        checkOutput("wr2_occ",  32'(bus.buffer_occupancy), 32'd2);
        checkOutput("wr2_data", 32'(bus.tx_packet_data), 32'hA5);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("rd1_occ",  32'(bus.buffer_occupancy), 32'd1);
        checkOutput("rd1_data", 32'(bus.tx_packet_data), 32'h3C);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkIdle("rd2");

        // Fill to 64, overflow on the 65th write, drain in order
        for (int i = 0; i < 64; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        checkOutput("fill_occ",  32'(bus.buffer_occupancy), 32'd64);
        checkOutput("fill_full", 32'(bus.full), 32'd1);
        checkOutput("fill_ovf0", 32'(bus.overflow), 32'd0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("ovf_flag", 32'(bus.overflow), 32'd1);
        checkOutput("ovf_occ",  32'(bus.buffer_occupancy), 32'd64);
        for (int i = 0; i < 64; i++) begin
            checkOutput("drain_data", 32'(bus.tx_packet_data), 32'(i));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkIdle("drained");
        checkOutput("drained_full", 32'(bus.full), 32'd0);

        // Underflow on empty; write+get while empty accepts the write
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("udf_flag", 32'(bus.underflow), 32'd1);
        checkOutput("udf_occ",  32'(bus.buffer_occupancy), 32'd0);
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
        checkOutput("emptyrw_occ",  32'(bus.buffer_occupancy), 32'd1);
        checkOutput("emptyrw_data", 32'(bus.tx_packet_data), 32'h5A);
        checkOutput("emptyrw_udf",  32'(bus.underflow), 32'd1);
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b1);
        checkIdle("flush");
        checkOutput("flush_udf", 32'(bus.underflow), 32'd0);
        checkOutput("flush_ovf", 32'(bus.overflow), 32'd0);

        // Occupancy 10 with rptr at 50, then 5 cycles of write+get across the wrap
        model.delete();
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b1, 8'(i + 100), 1'b0, 1'b0);
            model.push_back(8'(i + 100));
        end
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            expByte = model.pop_front();
        end
        checkOutput("wrap_occ10", 32'(bus.buffer_occupancy), 32'd10);
        for (int k = 0; k < 5; k++) begin
            checkOutput("wrap_rw_data", 32'(bus.tx_packet_data), 32'(model[0]));
            applyStimulus(1'b1, 8'(200 + k), 1'b1, 1'b0);
            expByte = model.pop_front();
            model.push_back(8'(200 + k));
            checkOutput("wrap_rw_occ", 32'(bus.buffer_occupancy), 32'd10);
        end
        for (int i = 0; i < 10; i++) begin
            checkOutput("wrap_drain", 32'(bus.tx_packet_data), 32'(model[0]));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            expByte = model.pop_front();
        end
        checkIdle("wrap_end");
        checkOutput("wrap_udf", 32'(bus.underflow), 32'd0);

`ifdef USB_TX_BUF_REPLAY_EN
        // Read four bytes, replay them, commit, then the full depth is writable
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("rp_read", 32'(bus.tx_packet_data), 32'(8'h11 * (i + 1)));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkIdle("rp_sent");
        bus.tx_replay = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        bus.tx_replay = 1'b0;
        checkOutput("rp_occ", 32'(bus.buffer_occupancy), 32'd4);
        checkOutput("rp_udf", 32'(bus.underflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("rp_reread", 32'(bus.tx_packet_data), 32'(8'h11 * (i + 1)));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        bus.tx_commit = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        bus.tx_commit = 1'b0;
        for (int i = 0; i < 64; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        checkOutput("cm_full", 32'(bus.full), 32'd1);
        checkOutput("cm_ovf",  32'(bus.overflow), 32'd0);
        checkOutput("cm_occ",  32'(bus.buffer_occupancy), 32'd64);

        // Without commit, the retained four bytes cost four entries
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        checkOutput("nc_full60", 32'(bus.full), 32'd1);
        checkOutput("nc_ovf60",  32'(bus.overflow), 32'd0);
        checkOutput("nc_occ60",  32'(bus.buffer_occupancy), 32'd60);
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
        checkOutput("nc_ovf61",  32'(bus.overflow), 32'd1);
        checkOutput("nc_occ61",  32'(bus.buffer_occupancy), 32'd60);
`endif

        // Asynchronous reset mid-stream drops everything immediately
        applyStimulus(1'b1, 8'h42, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        #2 n_rst = 1'b0;
        #1;
        checkIdle("async_rst");
        checkOutput("async_rst_udf", 32'(bus.underflow), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/usb_tx_data_buffer.md
# usb_tx_data_buffer

Byte FIFO directly upstream of the USB transmit path. The protocol/bus side writes payload bytes here. The transmitter pulls them one at a time with its data-request strobe. Current occupancy drives the transmitter's 7-bit packet-size input. Behaviour is first-word-fall-through, with sticky overflow/underflow flags and a synchronous flush.

## Interface
- DEPTH, 64, entry count; power of two, 2..64 (size output is 7 bits).
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- store_tx_data  in  1  write strobe, one byte per cycle.
- tx_data_in  in  8  byte written when store_tx_data=1.
- get_tx_packet_data  in  1  read strobe from transmitter (connects to its get_TX_packet_data).
- flush  in  1  synchronous clear of all contents and flags.
- tx_packet_data  out  8  head byte (connects to TX_packet_data).
- buffer_occupancy  out  7  unread bytes, 0..DEPTH (connects to TX_packet_data_size).
- full  out  1  no free entry.
- empty  out  1  no unread byte.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- tx_replay, tx_commit  in  1 each  present only with USB_TX_BUF_REPLAY_EN (see Configuration).

## Operation
- Storage: DEPTH x 8 register array. Write pointer wptr and read pointer rptr are each log2(DEPTH)+1 bits wide. Index = low bits; the extra MSB distinguishes full from empty. Pointers wrap modulo 2*DEPTH.
- buffer_occupancy = wptr - rptr (modular, zero-extended to 7 bits).
- empty = (occupancy == 0). full = (held bytes == DEPTH); held = occupancy without the replay feature.
- Write: store_tx_data & !full → mem[wptr] <= tx_data_in, wptr++. Write while full: data dropped, pointers unchanged, overflow <= 1.
- Read: get_tx_packet_data & !empty → rptr++. Read while empty: ignored, underflow <= 1.
- Simultaneous read and write, neither blocked: both occur, occupancy unchanged.
- Full with simultaneous read and write: write is still rejected, because full is evaluated on the pre-edge state. Read proceeds.
- Empty with simultaneous read and write: write accepted, read flagged as underflow.
- tx_packet_data = mem[rptr] when !empty, else 8'h00. Combinational from registers; no read latency.
- flush: pointers, occupancy and both sticky flags go to 0. Overrides any write/read in the same cycle. Memory contents are not cleared.
- overflow/underflow clear only on flush or reset.

## Timing
- Reset (async assert, release synchronous to clk):
  - wptr = rptr = 0; flags = 0.
  - Outputs: tx_packet_data=8'h00, buffer_occupancy=0, empty=1, full=0, overflow=0, underflow=0.
- Write at edge N: byte visible on tx_packet_data and counted in occupancy after edge N (from cycle N+1).
- get strobe sampled at edge N: next byte presented after edge N. The transmitter must capture the current byte in the same cycle it asserts get.
- Reset asserted mid-packet: all state is lost immediately. No partial-byte hazards, since the memory holds only whole bytes.
- Strobes are level-sampled every cycle; holding one high for k cycles means k operations.

## Configuration
- USB_TX_BUF_REPLAY_EN defined:
  - Adds a snapshot pointer spt, reset to 0, and inputs tx_replay and tx_commit.
  - held = wptr - spt; full = (held == DEPTH). Bytes already read are retained until commit.
  - tx_commit: spt <= rptr, which frees the transmitted bytes.
  - tx_replay: rptr <= spt, so the packet is resent after NAK/timeout.
  - Priority: flush > tx_replay > tx_commit. A get in the same cycle as tx_replay is ignored and does not set underflow.
  - flush also sets spt=0.
- USB_TX_BUF_REPLAY_EN undefined:
  - No spt and no replay/commit ports.
  - Read bytes are freed immediately; full = (occupancy == DEPTH).

## Structure
- Shared package usb_tx_pkg:
  - USB_TX_BUF_DEPTH = 64.
  - Byte and size widths (8, 7).
  - Pointer-width function clog2(DEPTH)+1.
- Sub-module tx_buffer_mem: DEPTH x 8 register file.
  - One synchronous write port, one asynchronous read port.
  - Holds no reset on contents.
- Pointer, flag and replay logic live in usb_tx_data_buffer.

## Test plan
- Reset, then idle → empty=1, full=0, buffer_occupancy=0, tx_packet_data=8'h00, both flags 0.
- Write 8'hA5, 8'h3C; pulse get twice → occupancy 1→2→1→0; tx_packet_data shows A5, then 3C, then 00; empty returns to 1.
- Write 64 bytes 0..63, then a 65th write of 8'hFF → full=1, occupancy=64, overflow=1. Read all 64 → data 0..63 in order, FF absent.
- get on empty buffer → underflow=1, rptr unchanged. Then flush → underflow=0, empty=1.
- At occupancy 10, assert write and get together for 5 cycles → occupancy stays 10 and data order is preserved, including across the pointer wrap.
- With USB_TX_BUF_REPLAY_EN:
  - Write 4 bytes, read 4, then tx_replay → occupancy=4, same 4 bytes again.
  - tx_commit after the reread → 64 entries writable.
  - Without the commit, the 61st write sets overflow.
